// File: rtl/dram_device_model_pkg.sv
// Shared command/state types and error codes for the single-bank DRAM device model.
package dram_dev_pkg;

  typedef enum logic [2:0] {NOP, ACT, PRE, RD, WR, ILLEGAL} cmd_e;

  typedef enum logic [1:0] {IDLE, ACTIVATING, ACTIVE, PRECHARGING} bank_state_e;

  localparam logic [2:0] ERR_ACT_OPEN   = 3'd1;
  localparam logic [2:0] ERR_COL_CLOSED = 3'd2;
  localparam logic [2:0] ERR_TRP        = 3'd3;
  localparam logic [2:0] ERR_ILLEGAL    = 3'd4;
  localparam logic [2:0] ERR_PRE_TRCD   = 3'd5;

  function automatic cmd_e decode_cmd(input logic csn, input logic rasn, input logic casn,
                                      input logic wen_all1, input logic wen_all0);
    cmd_e c;
    c = NOP;
    if (!csn) begin
      case ({rasn, casn})
        2'b00:   c = ILLEGAL;
        2'b01:   c = wen_all1 ? ACT : (wen_all0 ? PRE : ILLEGAL);
        2'b10:   c = wen_all1 ? RD : WR;
        default: c = NOP;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/dram_device_model_if.sv
// Pin bundle between a DRAM controller (master) and the device model (slave).
interface dram_device_model_if #(
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8,
  parameter int ADDR_W = 11
);
  logic              CSn;
  logic              RASn;
  logic              CASn;
  logic [STRB_W-1:0] WEn;
  logic [ADDR_W-1:0] addrDRAM;
  logic [DATA_W-1:0] writeD;
  logic [DATA_W-1:0] readQ;
  logic [1:0]        dramValid;
  logic              err_valid;
  logic [2:0]        err_code;

  modport master (
    output CSn, RASn, CASn, WEn, addrDRAM, writeD,
    input  readQ, dramValid, err_valid, err_code
  );

  modport slave (
    input  CSn, RASn, CASn, WEn, addrDRAM, writeD,
    output readQ, dramValid, err_valid, err_code
  );
endinterface

// File: rtl/dram_rd_pipe.sv
// Fixed-latency read return pipe; readQ only updates when a valid word leaves the pipe.
module dram_rd_pipe #(
  parameter int DATA_W = 32,
  parameter int LAT    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_readQ,
  output logic [1:0]        o_dramValid
);

  // The caller's registered array read is the first latency stage.
  if (LAT <= 1) begin : g_direct
    assign o_readQ     = i_data;
    assign o_dramValid = {2{i_valid}};
  end else begin : g_chain
    localparam int N = LAT - 1;
    logic [N-1:0]      r_v;
    logic [DATA_W-1:0] r_d [N];
    logic [N-1:0]      w_v_src;
    logic [DATA_W-1:0] w_d_src [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_src
      if (gi == 0) begin : g_head
        assign w_v_src[gi] = i_valid;
        assign w_d_src[gi] = i_data;
      end else begin : g_tail
        assign w_v_src[gi] = r_v[gi-1];
        assign w_d_src[gi] = r_d[gi-1];
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_v <= '0;
        for (int k = 0; k < N; k++) r_d[k] <= '0;
      end else begin
        for (int k = 0; k < N; k++) begin
          r_v[k] <= w_v_src[k];
          if (w_v_src[k]) r_d[k] <= w_d_src[k];
        end
      end
    end

    assign o_readQ     = r_d[N-1];
    assign o_dramValid = {2{r_v[N-1]}};
  end

endmodule

// File: rtl/dram_device_model.sv
// Single-bank DRAM pin-level responder: command decode, tRCD/tRP bank timing,
// byte-masked writes, fixed CAS-latency reads and protocol-violation reporting.
module dram_device_model
  import dram_dev_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int STRB_W  = DATA_W / 8,
  parameter int ADDR_W  = 11,
  parameter int ROW_W   = 11,
  parameter int COL_W   = 11,
  parameter int T_RP    = 4,
  parameter int T_RCD   = 4,
  parameter int CAS_LAT = 3
) (
  input logic                clk,
  input logic                rst,
  dram_device_model_if.slave bus
);

  localparam int DEPTH = 1 << (ROW_W + COL_W);
  localparam int TMR_W = $clog2(((T_RP > T_RCD) ? T_RP : T_RCD) + 1);
  localparam logic [TMR_W-1:0] RCD_LOAD = TMR_W'(T_RCD - 1);
  localparam logic [TMR_W-1:0] RP_LOAD  = TMR_W'(T_RP - 1);

  bank_state_e             r_state;
  bank_state_e             w_eff_state;
  logic [TMR_W-1:0]        r_timer;
  logic [ROW_W-1:0]        r_row;
  cmd_e                    w_cmd;
  logic                    w_err;
  logic [2:0]              w_err_code;
  logic                    w_do_rd;
  logic                    w_do_wr;
  logic [ROW_W+COL_W-1:0]  w_idx;
  logic [DATA_W-1:0]       r_mem [DEPTH];
  logic [DATA_W-1:0]       r_mem_q;
  logic                    r_rd_v;
  logic                    r_err_valid;
  logic [2:0]              r_err_code;

  assign w_cmd = decode_cmd(bus.CSn, bus.RASn, bus.CASn, &bus.WEn, ~|bus.WEn);
  assign w_idx = {r_row, bus.addrDRAM[COL_W-1:0]};

  // An expired timer makes the next state's commands legal in this same cycle.
  always_comb begin
    w_eff_state = r_state;
    if (r_state == ACTIVATING && r_timer == '0) w_eff_state = ACTIVE;
    if (r_state == PRECHARGING && r_timer == '0) w_eff_state = IDLE;
  end

  always_comb begin
    w_err      = 1'b1;
    w_err_code = '0;
    if (w_cmd == ILLEGAL)                                  w_err_code = ERR_ILLEGAL;
    else if (w_eff_state == PRECHARGING && w_cmd != NOP)  w_err_code = ERR_TRP;
    else if (w_cmd == ACT && w_eff_state != IDLE)          w_err_code = ERR_ACT_OPEN;
    else if (w_cmd == PRE && w_eff_state == ACTIVATING)    w_err_code = ERR_PRE_TRCD;
    else if ((w_cmd == RD || w_cmd == WR) && w_eff_state != ACTIVE)
                                                           w_err_code = ERR_COL_CLOSED;
    else                                                   w_err = 1'b0;
  end

  assign w_do_rd = (w_cmd == RD) && !w_err;
  assign w_do_wr = (w_cmd == WR) && !w_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      r_row       <= '0;
      r_err_valid <= 1'b0;
      r_err_code  <= '0;
      r_rd_v      <= 1'b0;
    end else begin
      r_err_valid <= w_err;
      r_err_code  <= w_err ? w_err_code : 3'd0;
      r_rd_v      <= w_do_rd;
      r_state     <= w_eff_state;
      case (w_eff_state)
        IDLE: begin
          if (!w_err && w_cmd == ACT) begin
            r_state <= ACTIVATING;
            r_timer <= RCD_LOAD;
            r_row   <= bus.addrDRAM[ROW_W-1:0];
          end else if (!w_err && w_cmd == PRE) begin
            r_state <= PRECHARGING;
            r_timer <= RP_LOAD;
          end
        end
        ACTIVATING:  r_timer <= r_timer - TMR_W'(1);
        ACTIVE: begin
          if (!w_err && w_cmd == PRE) begin
            r_state <= PRECHARGING;
            r_timer <= RP_LOAD;
          end
        end
        PRECHARGING: r_timer <= r_timer - TMR_W'(1);
        default:     r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (!bus.WEn[i]) r_mem[w_idx][i*8 +: 8] <= bus.writeD[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_mem_q <= '0;
    else if (w_do_rd) r_mem_q <= r_mem[w_idx];
  end

  dram_rd_pipe #(
    .DATA_W (DATA_W),
    .LAT    (CAS_LAT)
  ) u_rd_pipe (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (r_rd_v),
    .i_data      (r_mem_q),
    .o_readQ     (bus.readQ),
    .o_dramValid (bus.dramValid)
  );

  assign bus.err_valid = r_err_valid;
  assign bus.err_code  = r_err_code;

endmodule

// File: tb/tb_dram_device_model.sv
// Randomised + directed bench for dram_device_model against a cycle-stamp reference model.
module tb_dram_device_model;
  import dram_dev_pkg::*;

  localparam int T_RP    = 4;
  localparam int T_RCD   = 4;
  localparam int CAS_LAT = 3;
  localparam int COL_W   = 11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dram_device_model_if #(.DATA_W(32), .STRB_W(4), .ADDR_W(11)) bus ();

  dram_device_model #(
    .DATA_W(32), .STRB_W(4), .ADDR_W(11), .ROW_W(11), .COL_W(COL_W),
    .T_RP(T_RP), .T_RCD(T_RCD), .CAS_LAT(CAS_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {int due; logic [31:0] data;} rd_t;

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  bit          m_open = 0;
  bit          m_prech = 0;
  int          m_act_n = 0;
  int          m_pre_n = 0;
  int          m_row = 0;
  logic [31:0] m_mem [int];
  rd_t         m_q [$];
  logic [31:0] m_last = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic cmd_e tb_decode(input logic csn, input logic rasn, input logic casn,
                                     input logic [3:0] wen);
    if (csn) return NOP;
    if (!rasn && !casn) return ILLEGAL;
    if (!rasn) return (wen == 4'hF) ? ACT : ((wen == 4'h0) ? PRE : ILLEGAL);
    if (!casn) return (wen == 4'hF) ? RD : WR;
    return NOP;
  endfunction

  // Advance one clock, apply the sampled command to the model, then check outputs.
  task automatic step();
    cmd_e        c;
    int          e;
    int          key;
    int          col;
    bit          busy;
    bit          activating;
    logic [31:0] w;
    logic [3:0]  wen;
    logic [31:0] wd;
    @(posedge clk);
    cyc++;
    c   = tb_decode(bus.CSn, bus.RASn, bus.CASn, bus.WEn);
    col = int'(bus.addrDRAM);
    wen = bus.WEn;
    wd  = bus.writeD;
    e   = 0;
    busy = m_prech && (cyc - m_pre_n < T_RP);
    if (m_prech && !busy) m_prech = 0;
    activating = m_open && (cyc - m_act_n < T_RCD);
    key = (m_row << COL_W) | col;
    if (c == ILLEGAL) e = 4;
    else if (busy && c != NOP) e = 3;
    else begin
      case (c)
        ACT: if (m_open) e = 1;
             else begin m_open = 1; m_act_n = cyc; m_row = col; end
        PRE: if (activating) e = 5;
             else begin m_open = 0; m_prech = 1; m_pre_n = cyc; end
        RD:  if (!m_open || activating) e = 2;
             else m_q.push_back('{due: cyc + CAS_LAT - 1, data: m_mem[key]});
        WR:  if (!m_open || activating) e = 2;
             else begin
               w = m_mem.exists(key) ? m_mem[key] : 32'h0;
               for (int i = 0; i < 4; i++) if (!wen[i]) w[i*8 +: 8] = wd[i*8 +: 8];
               m_mem[key] = w;
             end
        default: ;
      endcase
    end
    #1;
    chk("err_valid", {31'b0, bus.err_valid}, {31'b0, e != 0});
    if (e != 0) chk("err_code", {29'b0, bus.err_code}, e);
    if (m_q.size() > 0 && m_q[0].due == cyc) begin
      chk("rd_valid", {30'b0, bus.dramValid}, 32'd3);
      chk("rd_data", bus.readQ, m_q[0].data);
      m_last = m_q[0].data;
      void'(m_q.pop_front());
    end else begin
      chk("idle_valid", {30'b0, bus.dramValid}, 32'd0);
      chk("hold_data", bus.readQ, m_last);
    end
    if (c != NOP)
      $display("cyc %0d %s addr=%h wd=%h wen=%b err=%0d", cyc, c.name(), col, wd, wen, e);
  endtask

  task automatic drive(input logic csn, input logic rasn, input logic casn, input logic [3:0] wen,
                       input int addr, input logic [31:0] data);
    bus.CSn = csn; bus.RASn = rasn; bus.CASn = casn; bus.WEn = wen;
    bus.addrDRAM = addr[10:0]; bus.writeD = data;
    step();
  endtask

  task automatic cmd(input cmd_e c, input int addr = 0, input logic [31:0] data = 0,
                     input logic [3:0] wen = 4'h0);
    case (c)
      ACT:     drive(1'b0, 1'b0, 1'b1, 4'hF, addr, data);
      PRE:     drive(1'b0, 1'b0, 1'b1, 4'h0, addr, data);
      RD:      drive(1'b0, 1'b1, 1'b0, 4'hF, addr, data);
      WR:      drive(1'b0, 1'b1, 1'b0, wen, addr, data);
      ILLEGAL: drive(1'b0, 1'b0, 1'b0, 4'($urandom), addr, data);
      default: drive(1'b1, 1'b1, 1'b1, 4'hF, addr, data);
    endcase
  endtask

  task automatic nops(input int k);
    repeat (k) cmd(NOP);
  endtask

  task automatic open_row(input int r);
    cmd(PRE); nops(T_RP - 1); cmd(ACT, r); nops(T_RCD - 1);
  endtask

  initial begin
    int          sel;
    int          col;
    int          key;
    logic [3:0]  wen;
    bus.CSn = 1'b1; bus.RASn = 1'b1; bus.CASn = 1'b1; bus.WEn = 4'hF;
    bus.addrDRAM = '0; bus.writeD = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_readQ", bus.readQ, 32'h0);
    chk("rst_valid", {30'b0, bus.dramValid}, 32'd0);
    chk("rst_err_valid", {31'b0, bus.err_valid}, 32'd0);
    chk("rst_err_code", {29'b0, bus.err_code}, 32'd0);
    rst = 1'b1;

    // Basic write then read, full mask.
    cmd(ACT, 5); nops(T_RCD - 1);
    cmd(WR, 'h12, 32'hDEADBEEF, 4'h0);
    cmd(RD, 'h12); nops(CAS_LAT);
    chk("basic_rd", bus.readQ, 32'hDEADBEEF);

    // Byte-masked write.
    cmd(WR, 'h20, 32'h11223344, 4'h0);
    cmd(WR, 'h20, 32'hAABBCCDD, 4'b1010);
    cmd(RD, 'h20); nops(CAS_LAT);
    chk("partial_wr", bus.readQ, 32'h11BB33DD);

    // Back-to-back reads.
    for (int i = 0; i < 4; i++) cmd(WR, i, 32'hA0 + i, 4'h0);
    for (int i = 0; i < 4; i++) cmd(RD, i);
    nops(CAS_LAT + 1);
    chk("b2b_last", bus.readQ, 32'hA3);

    // Timing and encoding violations.
    cmd(PRE); nops(T_RP - 1);
    cmd(ACT, 3);
    cmd(RD, 0);  chk("rd_early_code", {29'b0, bus.err_code}, 32'd2);
    nops(T_RCD);
    cmd(ACT, 3); chk("act_open_code", {29'b0, bus.err_code}, 32'd1);
    cmd(PRE); cmd(NOP);
    cmd(ACT, 4); chk("act_trp_code", {29'b0, bus.err_code}, 32'd3);
    nops(T_RP);
    cmd(ACT, 4);
    cmd(PRE);    chk("pre_trcd_code", {29'b0, bus.err_code}, 32'd5);
    cmd(ILLEGAL); chk("illegal_code", {29'b0, bus.err_code}, 32'd4);
    nops(T_RCD);

    // Row isolation.
    open_row(1); cmd(WR, 7, 32'h55, 4'h0);
    open_row(2); cmd(WR, 7, 32'h66, 4'h0);
    open_row(1); cmd(RD, 7); nops(CAS_LAT);
    chk("row_iso", bus.readQ, 32'h55);

    // Reset while a read is in flight.
    cmd(RD, 7); nops(1);
    rst = 1'b0;
    m_q.delete(); m_last = '0; m_open = 0; m_prech = 0;
    #1;
    chk("midrst_valid", {30'b0, bus.dramValid}, 32'd0);
    chk("midrst_readQ", bus.readQ, 32'h0);
    repeat (CAS_LAT + 1) begin
      @(posedge clk); cyc++; #1;
      chk("inrst_valid", {30'b0, bus.dramValid}, 32'd0);
      chk("inrst_readQ", bus.readQ, 32'h0);
    end
    rst = 1'b1;
    cmd(ACT, 0);
    chk("post_rst_act", {31'b0, bus.err_valid}, 32'd0);
    nops(T_RCD);

    // Randomised traffic over a small row/column window.
    repeat (600) begin
      sel = $urandom_range(0, 99);
      col = $urandom_range(0, 7);
      key = (m_row << COL_W) | col;
      if (sel < 20) cmd(NOP);
      else if (sel < 32) cmd(ACT, $urandom_range(0, 3));
      else if (sel < 42) cmd(PRE);
      else if (sel < 67) begin
        if (m_mem.exists(key)) cmd(RD, col);
        else cmd(WR, col, $urandom, 4'h0);
      end else if (sel < 94) begin
        wen = 4'($urandom_range(0, 14));
        if (!m_mem.exists(key)) wen = 4'h0;
        cmd(WR, col, $urandom, wen);
      end else begin
        case ($urandom_range(0, 2))
          0:       drive(1'b1, 1'($urandom), 1'($urandom), 4'($urandom), col, $urandom);
          1:       drive(1'b0, 1'b0, 1'b0, 4'($urandom), col, $urandom);
          default: drive(1'b0, 1'b1, 1'b1, 4'($urandom), col, $urandom);
        endcase
      end
    end
    nops(CAS_LAT + 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
